// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and constants for the IF/MEM SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

   // Width of the wait-state down-counter (supports up to 15 wait cycles)
   localparam int c_cnt_w = 4;

   // Default SRAM access time in cycles
   localparam int c_wait_cycles_def = 4;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_MEM = 2'd2,
      DONE     = 2'd3
   } state_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Fetch port, load/store port, freeze and SRAM signals of the
//                shared instruction/data SRAM arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // IF stage fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              flush;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;

   // MEM stage load/store port
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // Pipeline hold controls
   logic              freeze_if;
   logic              freeze_pipe;

   // SRAM port
   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   // Arbiter side
   modport slave (
      input  if_req, if_addr, flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
      output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
             sram_en, sram_we, sram_addr, sram_wdata
   );

   // Pipeline / SRAM side
   modport master (
      output if_req, if_addr, flush, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
      input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe,
             sram_en, sram_we, sram_addr, sram_wdata
   );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port SRAM between the IF fetch port and the
//                MEM load/store port. Each access runs a fixed number of wait
//                states, then a one-cycle DONE with a ready pulse. Data
//                accesses win over fetches; a flush makes an in-flight fetch
//                stale so its result is dropped.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = c_wait_cycles_def   // legal range 1..15
) (
   input  logic          clk,
   input  logic          rst,    // asynchronous, active-low
   mem_arbiter_if.slave  bus
);

   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WAIT_CYCLES - 1);

   state_t              state_q,     state_d;
   logic [c_cnt_w-1:0]  cnt_q,       cnt_d;
   logic                stale_q,     stale_d;
   logic                we_q,        we_d;
   logic                op_mem_q,    op_mem_d;     // current access belongs to MEM port
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

   logic                w_mem_req;
   logic                w_stale;     // stale including a flush arriving this cycle
   logic                w_busy;
   logic                w_mem_ready;
   logic                w_if_ready;

   // Next-state, counter and capture logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stale_d     = stale_q;
      we_d        = we_q;
      op_mem_d    = op_mem_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      w_mem_req   = bus.mem_rd_en | bus.mem_wr_en;
      w_stale     = stale_q | bus.flush;

      case (state_q)
         IDLE: begin
            if (w_mem_req) begin
               addr_d   = bus.mem_addr;
               wdata_d  = bus.mem_wdata;
               we_d     = bus.mem_wr_en;
               op_mem_d = 1'b1;
               cnt_d    = c_cnt_load;
               state_d  = BUSY_MEM;
            end else if (bus.if_req) begin
               addr_d   = bus.if_addr;
               we_d     = 1'b0;
               op_mem_d = 1'b0;
               stale_d  = 1'b0;
               cnt_d    = c_cnt_load;
               state_d  = BUSY_IF;
            end
         end
         BUSY_IF: begin
            stale_d = w_stale;
            if (cnt_q == '0) begin
               // A flush on the final wait cycle must still suppress the capture
               if (!w_stale) begin
                  if_rdata_d = bus.sram_rdata;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         BUSY_MEM: begin
            if (cnt_q == '0) begin
               // Stores leave the load data register untouched
               if (!we_q) begin
                  mem_rdata_d = bus.sram_rdata;
               end
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            // Requests are not sampled here so a still-held request is not re-accepted
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stale_q     <= 1'b0;
         we_q        <= 1'b0;
         op_mem_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stale_q     <= stale_d;
         we_q        <= we_d;
         op_mem_q    <= op_mem_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Outputs decode from the state register so reset clears them at once
   assign w_busy      = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
   assign w_mem_ready = (state_q == DONE) && op_mem_q;
   assign w_if_ready  = (state_q == DONE) && !op_mem_q && !stale_q;

   assign bus.sram_en     = w_busy;
   assign bus.sram_we     = (state_q == BUSY_MEM) && we_q;
   assign bus.sram_addr   = addr_q;
   assign bus.sram_wdata  = wdata_q;
   assign bus.if_rdata    = if_rdata_q;
   assign bus.if_ready    = w_if_ready;
   assign bus.mem_rdata   = mem_rdata_q;
   assign bus.mem_ready   = w_mem_ready;
   assign bus.freeze_pipe = (bus.mem_rd_en | bus.mem_wr_en) & ~w_mem_ready;
   assign bus.freeze_if   = ((bus.mem_rd_en | bus.mem_wr_en) & ~w_mem_ready)
                          | (bus.if_req & ~w_if_ready);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter (WAIT_CYCLES=4 and 1).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int W4 = 4;
   localparam int W1 = 1;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int unsigned cyc = 0;
   int          nchecks = 0;
   int          nerrors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Reference model state
   logic [31:0] ref_mem [256];
   logic [31:0] ref_rd;           // last load value the MEM port should hold
   int unsigned free_at;          // first cycle the W4 arbiter is idle again
   int unsigned free1;
   int unsigned n_en, n_we;       // expected SRAM enable / write-strobe cycles
   int unsigned cnt_en4 = 0, cnt_we4 = 0, cnt_en1 = 0;
   exp_t        mq[$], iq[$], q1[$];

   // Physical SRAMs: loaded from the reference image while in reset
   logic [31:0] sram4 [256];
   assign bus4.sram_rdata = sram4[bus4.sram_addr[9:2]];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) sram4[i] <= ref_mem[i];
      end else if (bus4.sram_en && bus4.sram_we) begin
         sram4[bus4.sram_addr[9:2]] <= bus4.sram_wdata;
      end
   end
   assign bus1.sram_rdata = 32'h1111_0000 + bus1.sram_addr;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor for the WAIT_CYCLES=4 instance
   always @(negedge clk) begin : p_mon4
      exp_t e;
      logic emr, eir;
      if (rst) begin
         emr = (mq.size() > 0) && (mq[0].cyc == cyc);
         eir = (iq.size() > 0) && (iq[0].cyc == cyc);
         check("mem_ready", bus4.mem_ready, emr);
         check("if_ready", bus4.if_ready, eir);
         if (emr) begin
            e = mq.pop_front();
            check("mem_rdata", bus4.mem_rdata, e.data);
         end
         if (eir) begin
            e = iq.pop_front();
            check("if_rdata", bus4.if_rdata, e.data);
         end
         check("freeze_pipe", bus4.freeze_pipe, (bus4.mem_rd_en | bus4.mem_wr_en) & ~emr);
         check("freeze_if", bus4.freeze_if,
               ((bus4.mem_rd_en | bus4.mem_wr_en) & ~emr) | (bus4.if_req & ~eir));
         if (bus4.sram_en) cnt_en4++;
         if (bus4.sram_we) cnt_we4++;
      end
   end

   // Monitor for the WAIT_CYCLES=1 instance
   always @(negedge clk) begin : p_mon1
      exp_t e;
      logic emr;
      if (rst) begin
         emr = (q1.size() > 0) && (q1[0].cyc == cyc);
         check("w1_mem_ready", bus1.mem_ready, emr);
         if (emr) begin
            e = q1.pop_front();
            check("w1_mem_rdata", bus1.mem_rdata, e.data);
         end
         if (bus1.sram_en) cnt_en1++;
      end
   end

   // Model: a request seen at drive cycle k is taken when the arbiter is idle,
   // finishes WAIT+1 cycles after that, and the arbiter is free the cycle after.
   function automatic int unsigned accept_at(int unsigned k);
      return (k > free_at) ? k : free_at;
   endfunction

   task automatic model_mem(int unsigned k, bit wr, logic [31:0] a, logic [31:0] d);
      int unsigned done;
      done = accept_at(k) + W4 + 1;
      if (wr) ref_mem[a[9:2]] = d;
      else    ref_rd = ref_mem[a[9:2]];
      mq.push_back('{done, ref_rd});
      free_at = done + 1;
      n_en += W4;
      if (wr) n_we += W4;
   endtask

   task automatic model_fetch(int unsigned k, logic [31:0] a, bit stale);
      int unsigned done;
      done = accept_at(k) + W4 + 1;
      if (!stale) iq.push_back('{done, ref_mem[a[9:2]]});
      free_at = done + 1;
      n_en += W4;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      return {22'd0, w, 2'b00};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = W4 mem_ready, 1 = W4 if_ready, 2 = W1 mem_ready
   task automatic wait_ready(int which, string name);
      int n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen) begin
         @(negedge clk);
         seen = (which == 0) ? bus4.mem_ready : (which == 1) ? bus4.if_ready : bus1.mem_ready;
         n++;
         if (!seen && n > 64) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s_timeout: ready not seen within %0d cycles, required a pulse", name, n);
            seen = 1'b1;
         end
      end
   endtask

   task automatic do_mem(bit wr, logic [31:0] a, logic [31:0] d);
      bus4.mem_addr  = a;
      bus4.mem_wdata = d;
      bus4.mem_wr_en = wr;
      bus4.mem_rd_en = !wr;
      model_mem(cyc, wr, a, d);
      wait_ready(0, "mem");
      step();
      bus4.mem_rd_en = 1'b0;
      bus4.mem_wr_en = 1'b0;
   endtask

   task automatic do_fetch(logic [31:0] a);
      bus4.if_req  = 1'b1;
      bus4.if_addr = a;
      model_fetch(cyc, a, 1'b0);
      wait_ready(1, "fetch");
      step();
      bus4.if_req = 1'b0;
   endtask

   task automatic do_both(bit wr, logic [31:0] ma, logic [31:0] d, logic [31:0] fa);
      bus4.mem_addr  = ma;
      bus4.mem_wdata = d;
      bus4.mem_wr_en = wr;
      bus4.mem_rd_en = !wr;
      bus4.if_req    = 1'b1;
      bus4.if_addr   = fa;
      model_mem(cyc, wr, ma, d);
      model_fetch(cyc, fa, 1'b0);
      wait_ready(0, "both_mem");
      step();
      bus4.mem_rd_en = 1'b0;
      bus4.mem_wr_en = 1'b0;
      wait_ready(1, "both_fetch");
      step();
      bus4.if_req = 1'b0;
   endtask

   // Fetch a_old, flush it off busy cycles into its access, then redirect to a_new
   task automatic do_flush(logic [31:0] a_old, logic [31:0] a_new, int off);
      bus4.if_req  = 1'b1;
      bus4.if_addr = a_old;
      model_fetch(cyc, a_old, 1'b1);
      repeat (off) step();
      bus4.flush   = 1'b1;
      bus4.if_addr = a_new;
      model_fetch(cyc, a_new, 1'b0);
      step();
      bus4.flush = 1'b0;
      wait_ready(1, "flush_fetch");
      step();
      bus4.if_req = 1'b0;
   endtask

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : p_main
      int unsigned kind;
      int unsigned we_before;
      logic [31:0] a, b, d;
      bit          wr;

      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[32'h10 >> 2]  = 32'hE3A0_0001;
      ref_mem[32'h100 >> 2] = 32'h0000_CAFE;
      ref_rd = '0;
      n_en = 0;
      n_we = 0;
      bus4.if_req = 1'b0; bus4.if_addr = '0; bus4.flush = 1'b0;
      bus4.mem_rd_en = 1'b0; bus4.mem_wr_en = 1'b0; bus4.mem_addr = '0; bus4.mem_wdata = '0;
      bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.flush = 1'b0;
      bus1.mem_rd_en = 1'b0; bus1.mem_wr_en = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_sram_en", bus4.sram_en, 1'b0);
      check("reset_if_rdata", bus4.if_rdata, 32'h0);
      check("reset_mem_rdata", bus4.mem_rdata, 32'h0);
      rst = 1'b1;
      free_at = cyc;
      free1   = cyc;

      // WAIT_CYCLES=1: back-to-back loads, one IDLE cycle between them
      bus1.mem_rd_en = 1'b1;
      bus1.mem_addr  = 32'h0;
      q1.push_back('{cyc + W1 + 1, 32'h1111_0000});
      wait_ready(2, "w1_load0");
      step();
      bus1.mem_addr = 32'h4;
      q1.push_back('{cyc + W1 + 1, 32'h1111_0004});
      wait_ready(2, "w1_load4");
      step();
      bus1.mem_rd_en = 1'b0;
      step();
      check("w1_sram_en_cycles", cnt_en1, 32'd2);

      // Directed cases
      do_fetch(32'h10);
      step();
      do_both(1'b0, 32'h100, 32'h0, 32'h20);
      we_before = cnt_we4;
      do_mem(1'b1, 32'h40, 32'hDEAD_BEEF);
      check("store_we_cycles", cnt_we4 - we_before, W4);
      do_mem(1'b0, 32'h40, 32'h0);
      do_flush(32'h30, 32'h80, 2);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 4);
         a    = rand_addr();
         b    = rand_addr();
         d    = $urandom;
         wr   = 1'($urandom_range(0, 1));
         case (kind)
            0: do_fetch(a);
            1: do_mem(1'b0, a, d);
            2: do_mem(1'b1, a, d);
            3: do_both(wr, a, d, b);
            default: do_flush(a, b, int'($urandom_range(1, W4)));
         endcase
         repeat ($urandom_range(0, 2)) step();
      end

      // Asynchronous reset in the second BUSY_MEM cycle of a load
      bus4.mem_rd_en = 1'b1;
      bus4.mem_addr  = 32'h100;
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check("arst_sram_en", bus4.sram_en, 1'b0);
      check("arst_sram_we", bus4.sram_we, 1'b0);
      check("arst_if_ready", bus4.if_ready, 1'b0);
      check("arst_mem_ready", bus4.mem_ready, 1'b0);
      check("arst_if_rdata", bus4.if_rdata, 32'h0);
      check("arst_mem_rdata", bus4.mem_rdata, 32'h0);
      check("arst_sram_addr", bus4.sram_addr, 32'h0);
      check("arst_sram_wdata", bus4.sram_wdata, 32'h0);
      bus4.mem_rd_en = 1'b0;
      n_en += 1;                 // the aborted load was enabled for one sampled cycle
      step();
      step();
      rst = 1'b1;
      free_at = cyc;
      ref_rd  = '0;
      repeat (5) step();
      check("post_rst_idle_en", bus4.sram_en, 1'b0);

      // Recovery after reset
      do_mem(1'b0, 32'h100, 32'h0);
      do_fetch(32'h10);
      repeat (3) step();

      check("mem_queue_drained", mq.size(), 32'd0);
      check("if_queue_drained", iq.size(), 32'd0);
      check("sram_en_cycles", cnt_en4, n_en);
      check("sram_we_cycles", cnt_we4, n_we);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule : tb_mem_arbiter
`default_nettype wire
